instr_trace_buffer: RTL and testbench
=====================================

# instr_trace_buffer

Synthesizable RV32I instruction-trace unit that sits beside the core in `MCU` and taps the fetch stream (PC and instruction word). Each observed instruction is classified by opcode into one of eight types. Per-type saturating counters are updated, and a {PC, instruction, type} record is pushed into a parametrised trace FIFO that is drained over a valid/ready port. It generalises the simulation-only decode/log monitor into hardware, with wider type coverage, configurable depth and width, and overflow accounting.

## Interface
Parameters:
- `XLEN`, 32, PC width.
- `DEPTH`, 16, trace FIFO entries; power of two, ≥2.
- `CNT_W`, 16, width of each per-type counter and of the overflow counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high. Clears FIFO, counters and overflow.
- `en` in 1: trace enable. When 0, input is ignored entirely.
- `instr_valid` in 1: `pc`/`instr` hold a retired/fetched instruction this cycle.
- `pc` in XLEN: instruction address.
- `instr` in 32: instruction word.
- `clear` in 1: synchronous zeroing of counters and overflow count; FIFO untouched.
- `trace_valid` out 1: FIFO head present.
- `trace_ready` in 1: consumer accepts head.
- `trace_pc` out XLEN: head PC.
- `trace_instr` out 32: head instruction.
- `trace_type` out 3: head type code.
- `level` out $clog2(DEPTH+1): current FIFO occupancy.
- `count_sel` in 3: type selector for `count_out`.
- `count_out` out CNT_W: counter of the selected type, combinational read of registers.
- `overflow_cnt` out CNT_W: records dropped because FIFO was full.

## Operation
- Observe event: `obs = en & instr_valid`.
- Type codes from `instr[6:0]`:
  - 0 R: 0110011
  - 1 I: 0010011, 0000011, 1100111
  - 2 S: 0100011
  - 3 B: 1100011
  - 4 U: 0110111, 0010111
  - 5 J: 1101111
  - 6 SYS: 1110011
  - 7 UNKNOWN: anything else
- Counters:
  - On `obs`, `cnt[type]` increments by 1 and saturates at 2^CNT_W−1.
  - Every observed instruction is counted, whether or not it enters the FIFO.
- Push:
  - Accepted when `obs & (!full | pop)`, where `pop = trace_valid & trace_ready`.
  - When full and popping in the same cycle, push and pop both occur and `level` is unchanged.
- Drop:
  - Occurs when `obs & full & !pop`.
  - Record is discarded and `overflow_cnt` increments, saturating.
- Empty:
  - `trace_valid`=0; `trace_ready` is ignored.
  - A push into an empty FIFO does not bypass to the outputs in the same cycle.
- `level`: `level_next = level + push − pop`, range 0..DEPTH.
- Pointers: log2(DEPTH) bits, natural wrap. Full/empty are derived from `level`.
- `clear`:
  - Counters and `overflow_cnt` go to 0.
  - `clear` has priority over a simultaneous increment; that cycle's event is not counted.
  - Push and drop logic still operate normally during `clear`.
- `reset` mid-operation: all state returns to reset values on the next edge. Pending records are lost and inputs in that cycle are ignored.

## Timing
- Reset values: `trace_valid`=0, `level`=0, `overflow_cnt`=0, all counters 0.
  - With `trace_valid`=0, `trace_pc`/`trace_instr`/`trace_type` are don't-care; they are driven 0 after reset.
- Push latency: record pushed at edge N gives `trace_valid`=1 after edge N, with head data stable. This is first-word fall-through from FIFO storage.
- Pop: head advances at the edge where `trace_valid & trace_ready`. The next entry is visible in the following cycle, so back-to-back pops give 1 record per cycle.
- Counter update visible on `count_out` in the cycle after the `obs` edge. `count_sel` to `count_out` is combinational.
- Handshake rules:
  - `trace_valid` must not drop without a pop, except on `reset`.
  - Head data is stable while `trace_valid & !trace_ready`.

## Structure
- Package `rv32i_trace_pkg`:
  - `instr_type_e` (3-bit enum T_R…T_UNKNOWN).
  - Opcode constants `OP_R`, `OP_I_ALU`, `OP_LOAD`, `OP_JALR`, `OP_S`, `OP_B`, `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_SYS`.
  - Function `classify(opcode)` returning `instr_type_e`.
  - Packed struct `trace_rec_t` {pc, instr, type}.
  - The testbench type-name function uses the same package.
- Sub-module `sync_fifo #(WIDTH, DEPTH)`:
  - Ports: push, pop, wdata, rdata, level, full, empty; synchronous reset.
  - Instantiated with WIDTH = XLEN+35.
- Top contains the classifier, counter array `cnt[8]`, overflow counter and push/drop logic.

## Test plan
- Reset, then push R (0x00B50533 @pc 0x0) and S (0x00A12023 @0x4) with `trace_ready`=0:
  - `level`=2, `trace_valid`=1, head pc 0x0 type 0.
  - `cnt[0]`=1, `cnt[2]`=1.
- Fill with DEPTH records, then 3 more with `trace_ready`=0:
  - `level`=DEPTH, `overflow_cnt`=3.
  - Per-type counts include all DEPTH+3 records.
- Full FIFO with push and `trace_ready`=1 in the same cycle:
  - `level` stays DEPTH, no overflow increment.
  - Drained order is FIFO order, with the new record last.
- Mix of LUI, AUIPC, JAL, JALR, ECALL and opcode 0x7F, 1 each:
  - `cnt[4]`=2, `cnt[5]`=1, `cnt[1]`=1, `cnt[6]`=1, `cnt[7]`=1.
- CNT_W=4, 20 R-type records:
  - `cnt[0]`=15, saturated.
  - `clear` together with another R-type gives `cnt[0]`=0; the FIFO `level` is unaffected.
- `reset` asserted with `level`=5 and `obs`=1:
  - Next cycle `level`=0, `trace_valid`=0, all counters 0.
  - With `en`=0 and `instr_valid`=1, nothing changes.

Source files
------------

// File: rtl/rv32i_trace_pkg.sv
// Shared RV32I trace definitions: instruction type codes, base opcodes,
// the opcode classifier and the trace record layout.
package rv32i_trace_pkg;

   typedef enum logic [2:0] {
      T_R       = 3'd0,
      T_I       = 3'd1,
      T_S       = 3'd2,
      T_B       = 3'd3,
      T_U       = 3'd4,
      T_J       = 3'd5,
      T_SYS     = 3'd6,
      T_UNKNOWN = 3'd7
   } instr_type_e;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I_ALU = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   localparam int unsigned TRACE_XLEN = 32;

   typedef struct packed {
      logic [TRACE_XLEN-1:0] pc;
      logic [31:0]           instr;
      instr_type_e           itype;
   } trace_rec_t;

   function automatic instr_type_e classify(input logic [6:0] opcode);
      instr_type_e t;
      case (opcode)
         OP_R:                       t = T_R;
         OP_I_ALU, OP_LOAD, OP_JALR: t = T_I;
         OP_S:                       t = T_S;
         OP_B:                       t = T_B;
         OP_LUI, OP_AUIPC:           t = T_U;
         OP_JAL:                     t = T_J;
         OP_SYS:                     t = T_SYS;
         default:                    t = T_UNKNOWN;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/instr_trace_buffer_sync_fifo.sv
// Synchronous first-word fall-through FIFO; occupancy counter drives full/empty,
// head data reads as zero while empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      empty   = (level == '0);
      full    = (level == LW'(DEPTH));
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      rdata   = empty ? '0 : mem[rptr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/instr_trace_buffer.sv
// Instruction trace unit: classifies observed fetches, keeps per-type and
// overflow saturating counters, and queues {pc, instr, type} records.
module instr_trace_buffer
   import rv32i_trace_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       instr_valid,
   input  logic [XLEN-1:0]            pc,
   input  logic [31:0]                instr,
   input  logic                       clear,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic [XLEN-1:0]            trace_pc,
   output logic [31:0]                trace_instr,
   output logic [2:0]                 trace_type,
   output logic [$clog2(DEPTH+1)-1:0] level,
   input  logic [2:0]                 count_sel,
   output logic [CNT_W-1:0]           count_out,
   output logic [CNT_W-1:0]           overflow_cnt
);

   localparam int unsigned WIDTH = XLEN + 35;

   logic             obs;
   instr_type_e      itype;
   logic             pop;
   logic             push;
   logic             drop;
   logic             full;
   logic             empty;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] rdata;
   logic [CNT_W-1:0] cnt [8];

   always_comb begin
      obs         = en & instr_valid;
      itype       = classify(instr[6:0]);
      trace_valid = ~empty;
      pop         = trace_valid & trace_ready;
      push        = obs & (~full | pop);
      drop        = obs & full & ~pop;
      wdata       = {pc, instr, itype};
      trace_pc    = rdata[WIDTH-1 -: XLEN];
      trace_instr = rdata[34:3];
      trace_type  = rdata[2:0];
      count_out   = cnt[count_sel];
   end

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .level (level),
      .full  (full),
      .empty (empty)
   );

   // clear wins over a same-cycle increment; the FIFO side is unaffected by it
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int unsigned k = 0; k < 8; k++) cnt[k] <= '0;
         overflow_cnt <= '0;
      end else begin
         if (obs && (cnt[itype] != '1)) cnt[itype] <= cnt[itype] + CNT_W'(1);
         if (drop && (overflow_cnt != '1)) overflow_cnt <= overflow_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed and randomized checks of instr_trace_buffer against a queue-based
// reference model; a CNT_W=4 instance covers counter saturation.
module tb_instr_trace_buffer;
   import rv32i_trace_pkg::*;

   localparam int DEPTH = 16;
   localparam int CMAX  = 65535;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        en_s = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] instr = '0;
   logic        clear = 1'b0;
   logic        trace_ready = 1'b0;
   logic [2:0]  count_sel = '0;

   logic        tv, s_tv;
   logic [31:0] tpc, tins, s_tpc, s_tins;
   logic [2:0]  ttype, s_ttype;
   logic [4:0]  lvl, s_lvl;
   logic [15:0] cout, ovf;
   logic [3:0]  s_cout, s_ovf;

   always #10 clk = ~clk;

   instr_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .en(en), .instr_valid(instr_valid), .pc(pc),
      .instr(instr), .clear(clear), .trace_valid(tv), .trace_ready(trace_ready),
      .trace_pc(tpc), .trace_instr(tins), .trace_type(ttype), .level(lvl),
      .count_sel(count_sel), .count_out(cout), .overflow_cnt(ovf)
   );

   instr_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(4)) dut_small (
      .clk(clk), .reset(reset), .en(en_s), .instr_valid(instr_valid), .pc(pc),
      .instr(instr), .clear(clear), .trace_valid(s_tv), .trace_ready(trace_ready),
      .trace_pc(s_tpc), .trace_instr(s_tins), .trace_type(s_ttype), .level(s_lvl),
      .count_sel(count_sel), .count_out(s_cout), .overflow_cnt(s_ovf)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      int          t;
   } rec_t;

   rec_t q[$];
   int   mcnt[8];
   int   movf;
   int   n_vec = 0;
   int   n_err = 0;

   logic [6:0] opc_tab [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                                7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F};

   function automatic string tname(input int t);
      instr_type_e e;
      e = instr_type_e'(t[2:0]);
      return e.name();
   endfunction

   function automatic int ref_type(input logic [6:0] op);
      case (op)
         7'b0110011:                         return 0;
         7'b0010011, 7'b0000011, 7'b1100111: return 1;
         7'b0100011:                         return 2;
         7'b1100011:                         return 3;
         7'b0110111, 7'b0010111:             return 4;
         7'b1101111:                         return 5;
         7'b1110011:                         return 6;
         default:                            return 7;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model(input bit e, input bit iv, input logic [31:0] p,
                        input logic [31:0] i, input bit rdy, input bit clr, input bit rst);
      bit obs, pp, full;
      rec_t r;
      if (rst) begin
         q.delete();
         for (int k = 0; k < 8; k++) mcnt[k] = 0;
         movf = 0;
         return;
      end
      obs  = e & iv;
      pp   = (q.size() > 0) && rdy;
      full = (q.size() == DEPTH);
      if (pp) void'(q.pop_front());
      if (obs) begin
         r.pc = p; r.ins = i; r.t = ref_type(i[6:0]);
         if (!full || pp) q.push_back(r);
         else if (movf < CMAX) movf++;
      end
      if (clr) begin
         for (int k = 0; k < 8; k++) mcnt[k] = 0;
         movf = 0;
      end else if (obs && mcnt[ref_type(i[6:0])] < CMAX) begin
         mcnt[ref_type(i[6:0])]++;
      end
   endtask

   task automatic check_all();
      chk("level", 64'(lvl), 64'(q.size()));
      chk("valid", 64'(tv), 64'(q.size() > 0));
      if (q.size() > 0) begin
         chk("head_pc", 64'(tpc), 64'(q[0].pc));
         chk("head_instr", 64'(tins), 64'(q[0].ins));
         chk("head_type", 64'(ttype), 64'(q[0].t));
      end
      chk("overflow", 64'(ovf), 64'(movf));
      for (int s = 0; s < 8; s++) begin
         count_sel = 3'(s);
         #1;
         chk($sformatf("cnt_%s", tname(s)), 64'(cout), 64'(mcnt[s]));
      end
   endtask

   task automatic step(input bit e, input bit iv, input logic [31:0] p, input logic [31:0] i,
                       input bit rdy, input bit clr, input bit rst);
      en = e; instr_valid = iv; pc = p; instr = i;
      trace_ready = rdy; clear = clr; reset = rst;
      @(posedge clk);
      model(e, iv, p, i, rdy, clr, rst);
      #1;
      check_all();
   endtask

   initial begin
      logic [31:0] ri;

      // reset state
      step(0, 0, 32'h0, 32'h0, 0, 0, 1);
      chk("rst_pc_zero", 64'(tpc), 64'h0);
      chk("rst_instr_zero", 64'(tins), 64'h0);
      chk("rst_type_zero", 64'(ttype), 64'h0);

      // R then S with consumer stalled
      step(1, 1, 32'h0, 32'h00B50533, 0, 0, 0);
      step(1, 1, 32'h4, 32'h00A12023, 0, 0, 0);
      chk("tp1_level", 64'(lvl), 64'd2);
      chk("tp1_type", 64'(ttype), 64'd0);
      count_sel = 3'd2; #1;
      chk("tp1_cnt_s", 64'(cout), 64'd1);

      // fill to DEPTH, then three drops
      for (int k = 2; k < DEPTH + 3; k++)
         step(1, 1, 32'(k * 4), {25'(k * 977), opc_tab[k % 11]}, 0, 0, 0);
      chk("fill_level", 64'(lvl), 64'(DEPTH));
      chk("fill_ovf", 64'(ovf), 64'd3);

      // push and pop while full, then drain
      step(1, 1, 32'h1000, 32'h00000073, 1, 0, 0);
      chk("fullpp_level", 64'(lvl), 64'(DEPTH));
      chk("fullpp_ovf", 64'(ovf), 64'd3);
      for (int k = 0; k < DEPTH; k++) begin
         if (k == DEPTH - 1) chk("drain_last_pc", 64'(tpc), 64'h1000);
         step(0, 0, 32'h0, 32'h0, 1, 0, 0);
      end

      // type mix
      step(0, 0, 32'h0, 32'h0, 0, 0, 1);
      step(1, 1, 32'h100, 32'h000012B7, 0, 0, 0);
      step(1, 1, 32'h104, 32'h00000297, 0, 0, 0);
      step(1, 1, 32'h108, 32'h0000006F, 0, 0, 0);
      step(1, 1, 32'h10C, 32'h00008067, 0, 0, 0);
      step(1, 1, 32'h110, 32'h00000073, 0, 0, 0);
      step(1, 1, 32'h114, 32'h0000007F, 0, 0, 0);
      count_sel = 3'd4; #1;
      chk("mix_cnt_u", 64'(cout), 64'd2);

      // saturation on the narrow-counter instance; main instance sees en=0
      step(0, 0, 32'h0, 32'h0, 0, 0, 1);
      en_s = 1'b1;
      for (int k = 0; k < 20; k++) step(0, 1, 32'(k * 4), 32'h00B50533, 0, 0, 0);
      count_sel = 3'd0; #1;
      chk("sat_cnt_r", 64'(s_cout), 64'd15);
      chk("sat_ovf", 64'(s_ovf), 64'd4);
      chk("sat_level", 64'(s_lvl), 64'(DEPTH));
      step(0, 1, 32'h200, 32'h00B50533, 0, 1, 0);
      count_sel = 3'd0; #1;
      chk("clr_cnt_r", 64'(s_cout), 64'd0);
      chk("clr_ovf", 64'(s_ovf), 64'd0);
      chk("clr_level", 64'(s_lvl), 64'(DEPTH));
      en_s = 1'b0;

      // reset mid-operation, then en=0 ignored
      step(0, 0, 32'h0, 32'h0, 0, 0, 1);
      for (int k = 0; k < 5; k++) step(1, 1, 32'(k * 4), 32'h00A12023, 0, 0, 0);
      chk("pre_rst_level", 64'(lvl), 64'd5);
      step(1, 1, 32'h40, 32'h00B50533, 0, 0, 1);
      chk("mid_rst_level", 64'(lvl), 64'd0);
      chk("mid_rst_valid", 64'(tv), 64'd0);
      step(0, 1, 32'h44, 32'h00B50533, 0, 0, 0);
      chk("en0_level", 64'(lvl), 64'd0);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         ri = $urandom;
         if ($urandom_range(0, 7) != 0) ri[6:0] = opc_tab[$urandom_range(0, 10)];
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom, ri,
              $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 199) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
